// File: rtl/fetch_pc_ctrl.sv
// Instruction-memory front end. After reset it loads a byte-stream program into
// instruction memory, then generates halfword fetch addresses (stall/redirect/halt).
module fetch_pc_ctrl #(
  parameter int MEM_DEPTH = 512
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        byte_ready_o,
  input  logic        stall_pipeline_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_addr_i,
  input  logic        halt_i,
  output logic        prog_we_o,
  output logic [15:0] prog_data_o,
  output logic [31:0] instr_addr_o,
  output logic        fetch_valid_o,
  output logic        loading_o,
  output logic        load_err_o
);

  localparam int WORD      = 32;
  localparam int HALF_WORD = 16;

  typedef enum logic [2:0] {
    HDR_LO,
    HDR_HI,
    DATA_LO,
    DATA_HI,
    WR,
    RUN,
    HALT
  } state_e;

  state_e               state_q, state_d;
  logic [15:0]          count_q, count_d;
  logic [7:0]           lo_q, lo_d;
  logic [WORD-1:0]      addr_q, addr_d;
  logic [HALF_WORD-1:0] data_q, data_d;
  logic                 err_q, err_d;

  logic [15:0]          hdr_count;
  logic                 hdr_too_big;
  logic [WORD-1:0]      last_idx;

  // Header count is assembled from the incoming high byte and the stored low byte.
  assign hdr_count   = {byte_i, count_q[7:0]};
  assign hdr_too_big = {1'b0, hdr_count} > 17'(MEM_DEPTH);
  assign last_idx    = {{(WORD-16){1'b0}}, count_q} - WORD'(1);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours; blocking here would create races.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= HDR_LO;
      count_q <= '0;
      lo_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      lo_q    <= lo_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // NOTE: every next-state signal is given its hold value first, so no path
  // through the case statement leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    lo_d    = lo_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;

    unique case (state_q)
      HDR_LO: begin
        if (byte_valid_i) begin
          count_d = {8'h00, byte_i};
          state_d = HDR_HI;
        end
      end
      HDR_HI: begin
        if (byte_valid_i) begin
          count_d = hdr_count;
          addr_d  = '0;
          if (hdr_count == 16'd0) begin
            state_d = RUN;
          end else if (hdr_too_big) begin
            state_d = HALT;
            err_d   = 1'b1;
          end else begin
            state_d = DATA_LO;
          end
        end
      end
      DATA_LO: begin
        if (byte_valid_i) begin
          lo_d    = byte_i;
          state_d = DATA_HI;
        end
      end
      DATA_HI: begin
        if (byte_valid_i) begin
          data_d  = {byte_i, lo_q};
          state_d = WR;
        end
      end
      WR: begin
        // addr_q already holds the index being written this cycle.
        if (addr_q == last_idx) begin
          addr_d  = '0;
          state_d = RUN;
        end else begin
          addr_d  = addr_q + WORD'(1);
          state_d = DATA_LO;
        end
      end
      RUN: begin
        if (halt_i) begin
          state_d = HALT;
        end else if (redirect_i) begin
          addr_d = redirect_addr_i;
        end else if (!stall_pipeline_i) begin
          addr_d = addr_q + WORD'(1);
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = HDR_LO;
      end
    endcase
  end

  assign byte_ready_o  = (state_q == HDR_LO) || (state_q == HDR_HI) ||
                         (state_q == DATA_LO) || (state_q == DATA_HI);
  assign loading_o     = byte_ready_o || (state_q == WR);
  assign prog_we_o     = (state_q == WR);
  assign fetch_valid_o = (state_q == RUN);
  assign prog_data_o   = data_q;
  assign instr_addr_o  = addr_q;
  assign load_err_o    = err_q;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Self-checking bench for fetch_pc_ctrl: byte-count based loader model plus a
// PC model applying halt > redirect > stall > increment each cycle.
module tb_fetch_pc_ctrl;

  typedef logic [7:0] byte_t;

  localparam int MEM_DEPTH = 512;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        byte_valid_i = 1'b0;
  logic [7:0]  byte_i = '0;
  logic        byte_ready_o;
  logic        stall_pipeline_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_addr_i = '0;
  logic        halt_i = 1'b0;
  logic        prog_we_o;
  logic [15:0] prog_data_o;
  logic [31:0] instr_addr_o;
  logic        fetch_valid_o;
  logic        loading_o;
  logic        load_err_o;

  int errors = 0;
  int checks = 0;

  byte_t       stream[$];
  logic [31:0] m_pc;
  bit          m_halted;
  int          last_nwr;

  fetch_pc_ctrl #(.MEM_DEPTH(MEM_DEPTH)) dut (
    .clk_i           (clk_i),
    .reset_n_i       (reset_n_i),
    .byte_valid_i    (byte_valid_i),
    .byte_i          (byte_i),
    .byte_ready_o    (byte_ready_o),
    .stall_pipeline_i(stall_pipeline_i),
    .redirect_i      (redirect_i),
    .redirect_addr_i (redirect_addr_i),
    .halt_i          (halt_i),
    .prog_we_o       (prog_we_o),
    .prog_data_o     (prog_data_o),
    .instr_addr_o    (instr_addr_o),
    .fetch_valid_o   (fetch_valid_o),
    .loading_o       (loading_o),
    .load_err_o      (load_err_o)
  );

  always #5 clk_i = ~clk_i;

  // Holds reset for one edge and checks every output's reset value; returns at a
  // negedge with reset released.
  task automatic test_reset(input string tag);
    @(negedge clk_i);
    reset_n_i = 1'b0;
    byte_valid_i = 1'b0; stall_pipeline_i = 1'b0; redirect_i = 1'b0; halt_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if ({prog_we_o, fetch_valid_o, load_err_o, loading_o, byte_ready_o} !== 5'b00011) begin
      errors++;
      $display("FAIL %s flags we/fv/err/ld/rdy got %b want 00011", tag,
               {prog_we_o, fetch_valid_o, load_err_o, loading_o, byte_ready_o});
    end
    checks++;
    if (instr_addr_o !== 32'd0 || prog_data_o !== 16'd0) begin
      errors++;
      $display("FAIL %s addr/data got %h/%h want 0/0", tag, instr_addr_o, prog_data_o);
    end
    reset_n_i = 1'b1;
  endtask

  // Streams the global byte queue with random valid gaps. Expected loader
  // behaviour is derived from how many bytes have been accepted: every second
  // data byte is followed by one write cycle. Requires a header count of
  // 0..MEM_DEPTH. Ends at the negedge of the first RUN cycle.
  task automatic load_stream(input int valid_pct, input string tag);
    int    taken = 0;
    int    nwr = 0;
    int    n = -1;
    bit    wr_pend = 0;
    bit    done = 0;
    bit    v;
    int    budget;
    stall_pipeline_i = 1'b0; redirect_i = 1'b0; halt_i = 1'b0;
    for (budget = 0; budget < 6000 && !done; budget++) begin
      @(negedge clk_i);
      if (wr_pend) begin
        checks++;
        if (prog_we_o !== 1'b1 || byte_ready_o !== 1'b0 || loading_o !== 1'b1) begin
          errors++;
          $display("FAIL %s write cycle we/rdy/ld got %b%b%b want 101", tag,
                   prog_we_o, byte_ready_o, loading_o);
        end
        checks++;
        if (instr_addr_o !== 32'((taken - 4) / 2) ||
            prog_data_o !== {stream[taken-1], stream[taken-2]}) begin
          errors++;
          $display("FAIL %s write got %h@%0d want %h@%0d", tag, prog_data_o, instr_addr_o,
                   {stream[taken-1], stream[taken-2]}, (taken - 4) / 2);
        end
        byte_valid_i = ($urandom_range(1) == 1);
        byte_i = 8'($urandom);
        wr_pend = 0;
        nwr++;
        if (nwr == n) done = 1;
      end else begin
        checks++;
        if (prog_we_o !== 1'b0 || byte_ready_o !== 1'b1 || loading_o !== 1'b1 ||
            fetch_valid_o !== 1'b0) begin
          errors++;
          $display("FAIL %s byte cycle we/rdy/ld/fv got %b%b%b%b want 0110", tag,
                   prog_we_o, byte_ready_o, loading_o, fetch_valid_o);
        end
        v = (int'($urandom_range(99)) < valid_pct) && (taken < stream.size());
        byte_valid_i = v;
        byte_i = v ? stream[taken] : 8'($urandom);
        if (v) begin
          taken++;
          if (taken == 2) begin
            n = int'({stream[1], stream[0]});
            if (n == 0) done = 1;
          end else if (taken >= 4 && (taken % 2) == 0) begin
            wr_pend = 1;
          end
        end
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s load timeout got %0d writes want %0d", tag, nwr, n);
    end
    @(negedge clk_i);
    byte_valid_i = 1'b0;
    checks++;
    if (fetch_valid_o !== 1'b1 || instr_addr_o !== 32'd0 || loading_o !== 1'b0 ||
        byte_ready_o !== 1'b0 || prog_we_o !== 1'b0) begin
      errors++;
      $display("FAIL %s first fetch fv/addr/ld/rdy/we got %b/%h/%b%b%b want 1/0/000", tag,
               fetch_valid_o, instr_addr_o, loading_o, byte_ready_o, prog_we_o);
    end
    last_nwr = nwr;
    m_pc = 32'd0;
    m_halted = 0;
  endtask

  // One run-phase cycle: apply inputs, advance the PC model, check next state.
  task automatic run_step(input bit h, input bit r, input logic [31:0] ra, input bit s,
                          input string tag);
    halt_i = h; redirect_i = r; redirect_addr_i = ra; stall_pipeline_i = s;
    byte_valid_i = ($urandom_range(1) == 1);
    byte_i = 8'($urandom);
    if (!m_halted) begin
      if (h)       m_halted = 1;
      else if (r)  m_pc = ra;
      else if (!s) m_pc = m_pc + 32'd1;
    end
    @(negedge clk_i);
    checks++;
    if (instr_addr_o !== m_pc || fetch_valid_o !== !m_halted || byte_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL %s pc/fv/rdy got %h/%b/%b want %h/%b/0", tag, instr_addr_o,
               fetch_valid_o, byte_ready_o, m_pc, !m_halted);
    end
  endtask

  task automatic feed(input byte_t b);
    byte_valid_i = 1'b1;
    byte_i = b;
    @(negedge clk_i);
    byte_valid_i = 1'b0;
  endtask

  task automatic test_basic_load;
    test_reset("reset_basic");
    stream = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56};
    load_stream(100, "basic_load");
    checks++;
    if (last_nwr != 2) begin
      errors++;
      $display("FAIL basic_load write count got %0d want 2", last_nwr);
    end
    for (int i = 0; i < 3; i++) run_step(0, 0, 32'd0, 0, "basic_fetch");
  endtask

  task automatic test_empty_header;
    test_reset("reset_empty");
    stream = '{8'h00, 8'h00};
    load_stream(70, "empty_header");
    checks++;
    if (last_nwr != 0) begin
      errors++;
      $display("FAIL empty_header writes got %0d want 0", last_nwr);
    end
  endtask

  task automatic test_header_error;
    test_reset("reset_err");
    feed(8'h01);
    feed(8'h02);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (load_err_o !== 1'b1 || fetch_valid_o !== 1'b0 || byte_ready_o !== 1'b0 ||
          loading_o !== 1'b0 || prog_we_o !== 1'b0 || instr_addr_o !== 32'd0) begin
        errors++;
        $display("FAIL header_err err/fv/rdy/ld/we/addr got %b%b%b%b%b/%h want 10000/0",
                 load_err_o, fetch_valid_o, byte_ready_o, loading_o, prog_we_o, instr_addr_o);
      end
      redirect_i = 1'b1; redirect_addr_i = 32'h77;
      feed(8'($urandom));
    end
    redirect_i = 1'b0;
  endtask

  task automatic test_max_depth;
    test_reset("reset_max");
    stream = '{8'h00, 8'h02};
    for (int i = 0; i < 2 * MEM_DEPTH; i++) stream.push_back(8'($urandom));
    load_stream(100, "max_depth");
    checks++;
    if (last_nwr != MEM_DEPTH || load_err_o !== 1'b0) begin
      errors++;
      $display("FAIL max_depth writes/err got %0d/%b want %0d/0", last_nwr, load_err_o,
               MEM_DEPTH);
    end
  endtask

  task automatic test_stall_redirect;
    test_reset("reset_stall");
    stream = '{8'h00, 8'h00};
    load_stream(100, "stall_load");
    for (int i = 0; i < 5; i++) run_step(0, 0, 32'd0, 0, "to_pc5");
    for (int i = 0; i < 3; i++) run_step(0, 0, 32'd0, 1, "stall_hold");
    run_step(0, 1, 32'h40, 1, "redirect_over_stall");
    run_step(0, 0, 32'd0, 0, "after_redirect");
    checks++;
    if (instr_addr_o !== 32'h41) begin
      errors++;
      $display("FAIL after_redirect addr got %h want 00000041", instr_addr_o);
    end
    run_step(0, 1, 32'hFFFF_FFFF, 0, "wrap_setup");
    run_step(0, 0, 32'd0, 0, "wrap_zero");
  endtask

  task automatic test_halt;
    test_reset("reset_halt");
    stream = '{8'h00, 8'h00};
    load_stream(100, "halt_load");
    for (int i = 0; i < 9; i++) run_step(0, 0, 32'd0, 0, "to_pc9");
    run_step(1, 1, 32'h55, 0, "halt_wins");
    checks++;
    if (instr_addr_o !== 32'd9 || fetch_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL halt_frozen addr/fv got %h/%b want 00000009/0", instr_addr_o, fetch_valid_o);
    end
    run_step(0, 1, 32'h123, 0, "halt_redirect_ignored");
    run_step(0, 0, 32'd0, 0, "halt_hold");
  endtask

  task automatic test_reset_mid_load;
    test_reset("reset_mid1");
    feed(8'h03); feed(8'h00); feed(8'h11); feed(8'h22);
    @(negedge clk_i);
    feed(8'h33);
    checks++;
    if (byte_ready_o !== 1'b1 || instr_addr_o !== 32'd1 || prog_data_o !== 16'h2211) begin
      errors++;
      $display("FAIL mid_load rdy/addr/data got %b/%h/%h want 1/1/2211", byte_ready_o,
               instr_addr_o, prog_data_o);
    end
    test_reset("reset_mid_load");
    stream = '{8'h01, 8'h00, 8'hAA, 8'hBB};
    load_stream(60, "reload");
    checks++;
    if (last_nwr != 1) begin
      errors++;
      $display("FAIL reload writes got %0d want 1", last_nwr);
    end
  endtask

  task automatic test_random;
    int n;
    for (int rep = 0; rep < 3; rep++) begin
      test_reset("reset_rand");
      n = int'($urandom_range(1, 6));
      stream = '{8'(n), 8'h00};
      for (int i = 0; i < 2 * n; i++) stream.push_back(8'($urandom));
      load_stream(50, "rand_load");
      for (int i = 0; i < 200; i++)
        run_step($urandom_range(99) == 0, $urandom_range(9) == 0, $urandom,
                 $urandom_range(3) == 0, "rand_run");
    end
  endtask

  initial begin
    test_basic_load();
    test_empty_header();
    test_header_error();
    test_max_depth();
    test_stall_redirect();
    test_halt();
    test_reset_mid_load();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
